// File: rtl/mem_adapter_pkg.sv
// mem_adapter_pkg: shared types and helpers for the sub-word memory adapter
package mem_adapter_pkg;
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } mem_size_t;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } mem_adapt_state_t;
  function automatic logic [2:0] size_bytes(input mem_size_t size);
    return size == SIZE_B ? 3'd1 : size == SIZE_H ? 3'd2 : size == SIZE_W ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/subword_lane_merge.sv
// subword_lane_merge: byte-lane enables, store merge and load extract/extend over a two-word window
module subword_lane_merge
  import mem_adapter_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_size_t   size_i,
  input  logic        signed_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  output logic [31:0] merged0_o,
  output logic [31:0] merged1_o,
  output logic [31:0] load_data_o
);
  logic [2:0]  nbytes;
  logic [7:0]  lane_en;
  logic [63:0] byte_mask, window, store_shifted, merged;
  logic [31:0] extracted;
  assign nbytes = size_bytes(size_i);
  assign lane_en = (nbytes == 3'd1 ? 8'h01 : nbytes == 3'd2 ? 8'h03 : nbytes == 3'd4 ? 8'h0f : 8'h00) << off_i;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign byte_mask[8*i +: 8] = {8{lane_en[i]}};
  end
  assign window = {word1_i, word0_i};
  assign store_shifted = {32'd0, store_data_i} << {off_i, 3'b000};
  assign merged = (window & ~byte_mask) | (store_shifted & byte_mask);
  assign merged0_o = merged[31:0];
  assign merged1_o = merged[63:32];
  assign extracted = 32'(window >> {off_i, 3'b000});
  assign load_data_o = nbytes == 3'd1 ? {{24{signed_i & extracted[7]}}, extracted[7:0]} :
                       nbytes == 3'd2 ? {{16{signed_i & extracted[15]}}, extracted[15:0]} : extracted;
endmodule

// File: rtl/mem_subword_adapter.sv
// mem_subword_adapter: turns byte/half/word accesses at any address into aligned 32-bit word reads and writes
module mem_subword_adapter
  import mem_adapter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            in_req_valid,
  output logic            out_req_ready,
  input  logic            in_req_store,
  input  logic [1:0]      in_req_size,
  input  logic            in_req_signed,
  input  logic [XLEN-1:0] in_req_address,
  input  logic [XLEN-1:0] in_req_data,
  output logic            out_resp_valid,
  input  logic            in_resp_ready,
  output logic [XLEN-1:0] out_resp_data,
  output logic            out_resp_exception,
  output logic [XLEN-1:0] out_mem_read_address,
  output logic [XLEN-1:0] out_mem_write_address,
  output logic [XLEN-1:0] out_mem_write_data,
  output logic            out_mem_write_enable,
  input  logic [XLEN-1:0] in_mem_read_data,
  input  logic            in_mem_read_exception,
  input  logic            in_mem_write_exception
);
  mem_adapt_state_t state_q, state_d;
  mem_size_t        size_q, size_d, req_size;
  logic             store_q, store_d, signed_q, signed_d, cross_q, cross_d, exc_q, exc_d;
  logic [XLEN-1:0]  addr_q, addr_d, data_q, data_d, word0_q, word0_d, word1_q, word1_d;
  logic [XLEN-1:0]  w0, w1, merged0, merged1, load_data;
  logic             illegal, aligned_word;
  assign req_size = mem_size_t'(in_req_size);
  assign illegal = req_size == SIZE_X;
  assign aligned_word = req_size == SIZE_W && in_req_address[1:0] == 2'b00;
  assign w0 = {addr_q[XLEN-1:2], 2'b00};
  assign w1 = w0 + XLEN'(4);
  subword_lane_merge u_merge (
    .off_i        (addr_q[1:0]),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .store_data_i (data_q),
    .word0_i      (word0_q),
    .word1_i      (word1_q),
    .merged0_o    (merged0),
    .merged1_o    (merged1),
    .load_data_o  (load_data)
  );
  // next-state: accept and latch, read word(s), write merged word(s), hold response
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    signed_d = signed_q;
    size_d   = size_q;
    cross_d  = cross_q;
    addr_d   = addr_q;
    data_d   = data_q;
    word0_d  = word0_q;
    word1_d  = word1_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: if (in_req_valid) begin
        store_d  = in_req_store;
        signed_d = in_req_signed;
        size_d   = req_size;
        addr_d   = in_req_address;
        data_d   = in_req_data;
        cross_d  = {1'b0, in_req_address[1:0]} + size_bytes(req_size) > 3'd4;
        exc_d    = illegal;
        state_d  = illegal ? RESP : (in_req_store && aligned_word) ? WR0 : RD0;
      end
      RD0: begin
        word0_d = in_mem_read_data;
        exc_d   = exc_q | in_mem_read_exception;
        state_d = cross_q ? RD1 : (store_q && !exc_d) ? WR0 : RESP;
      end
      RD1: begin
        word1_d = in_mem_read_data;
        exc_d   = exc_q | in_mem_read_exception;
        state_d = (store_q && !exc_d) ? WR0 : RESP;
      end
      WR0: begin
        exc_d   = exc_q | in_mem_write_exception;
        state_d = (cross_q && !in_mem_write_exception) ? WR1 : RESP;
      end
      WR1: begin
        exc_d   = exc_q | in_mem_write_exception;
        state_d = RESP;
      end
      RESP: state_d = in_resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and latched request registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SIZE_B;
      cross_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      word0_q  <= '0;
      word1_q  <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      cross_q  <= cross_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      word0_q  <= word0_d;
      word1_q  <= word1_d;
      exc_q    <= exc_d;
    end
  end
  assign out_req_ready         = state_q == IDLE;
  assign out_resp_valid        = state_q == RESP;
  assign out_resp_exception    = out_resp_valid && exc_q;
  assign out_resp_data         = (out_resp_valid && !store_q && !exc_q) ? load_data : '0;
  assign out_mem_read_address  = state_q == RD0 ? w0 : state_q == RD1 ? w1 : '0;
  assign out_mem_write_address = state_q == WR0 ? w0 : state_q == WR1 ? w1 : '0;
  assign out_mem_write_data    = state_q == WR0 ? merged0 : state_q == WR1 ? merged1 : '0;
  assign out_mem_write_enable  = state_q == WR0 || state_q == WR1;
endmodule

// File: tb/tb_mem_subword_adapter.sv
// tb_mem_subword_adapter: table-driven check of the sub-word adapter against a word memory model
module tb_mem_subword_adapter;
  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_exc;
    int          lat;
    int          rd;
    int          wr;
    logic [1:0]  inj;
    logic [31:0] inj_addr;
    logic        chk;
    logic [31:0] chk_addr;
    logic [31:0] chk_val;
  } vec_t;
  logic        CLK, RESET;
  logic        in_req_valid, out_req_ready, in_req_store, in_req_signed;
  logic [1:0]  in_req_size;
  logic [31:0] in_req_address, in_req_data;
  logic        out_resp_valid, in_resp_ready, out_resp_exception;
  logic [31:0] out_resp_data;
  logic [31:0] out_mem_read_address, out_mem_write_address, out_mem_write_data, in_mem_read_data;
  logic        out_mem_write_enable, in_mem_read_exception, in_mem_write_exception;
  logic [31:0] mem [0:255];
  logic        preload;
  logic [1:0]  inj;
  logic [31:0] inj_addr;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        vecs [22];
  mem_subword_adapter #(.XLEN(32)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .in_req_valid           (in_req_valid),
    .out_req_ready          (out_req_ready),
    .in_req_store           (in_req_store),
    .in_req_size            (in_req_size),
    .in_req_signed          (in_req_signed),
    .in_req_address         (in_req_address),
    .in_req_data            (in_req_data),
    .out_resp_valid         (out_resp_valid),
    .in_resp_ready          (in_resp_ready),
    .out_resp_data          (out_resp_data),
    .out_resp_exception     (out_resp_exception),
    .out_mem_read_address   (out_mem_read_address),
    .out_mem_write_address  (out_mem_write_address),
    .out_mem_write_data     (out_mem_write_data),
    .out_mem_write_enable   (out_mem_write_enable),
    .in_mem_read_data       (in_mem_read_data),
    .in_mem_read_exception  (in_mem_read_exception),
    .in_mem_write_exception (in_mem_write_exception)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  assign in_mem_read_data       = mem[out_mem_read_address[9:2]];
  assign in_mem_read_exception  = inj == 2'd1 && out_mem_read_address == inj_addr;
  assign in_mem_write_exception = inj == 2'd2 && out_mem_write_enable && out_mem_write_address == inj_addr;
  // word memory model: preload, then commit strobed writes that did not fault
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h44332211;
      mem[8'h41] <= 32'h88776655;
      mem[8'hFF] <= 32'hA1000000;
      mem[8'h00] <= 32'h000000B2;
    end else if (out_mem_write_enable && !in_mem_write_exception) begin
      mem[out_mem_write_address[9:2]] <= out_mem_write_data;
    end
  end
  // count write strobes and busy cycles that are neither writing nor responding (reads)
  always @(posedge CLK) begin
    if (out_mem_write_enable) wr_cnt <= wr_cnt + 1;
    if (!out_req_ready && !out_resp_valid && !out_mem_write_enable) rd_cnt <= rd_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int st, input int sz, input int sg, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_data, input int exc,
                              input int lat, input int rd, input int wr, input int inj_k,
                              input logic [31:0] inj_a, input int chk, input logic [31:0] chk_addr,
                              input logic [31:0] chk_val);
    vec_t v;
    v.st = st[0]; v.sz = sz[1:0]; v.sg = sg[0]; v.addr = addr; v.data = data; v.exp_data = exp_data;
    v.exp_exc = exc[0]; v.lat = lat; v.rd = rd; v.wr = wr; v.inj = inj_k[1:0]; v.inj_addr = inj_a;
    v.chk = chk[0]; v.chk_addr = chk_addr; v.chk_val = chk_val;
    return v;
  endfunction
  task automatic run_vec(input string id, input vec_t v);
    int lat, rd0, wr0, t;
    t = 0;
    while (!out_req_ready && t < 20) begin @(negedge CLK); t++; end
    check({id, " ready"}, 32'(out_req_ready), 32'd1);
    inj = v.inj; inj_addr = v.inj_addr;
    in_req_valid = 1'b1; in_req_store = v.st; in_req_size = v.sz; in_req_signed = v.sg;
    in_req_address = v.addr; in_req_data = v.data;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    in_req_valid = 1'b0;
    while (!out_resp_valid && lat < 10) begin @(negedge CLK); lat++; end
    check({id, " latency"}, 32'(lat), 32'(v.lat));
    check({id, " exc"}, 32'(out_resp_exception), 32'(v.exp_exc));
    if (!v.exp_exc) check({id, " data"}, out_resp_data, v.exp_data);
    check({id, " reads"}, 32'(rd_cnt - rd0), 32'(v.rd));
    check({id, " writes"}, 32'(wr_cnt - wr0), 32'(v.wr));
    @(posedge CLK);
    @(negedge CLK);
    inj = 2'd0;
    if (v.chk) check({id, " mem"}, mem[v.chk_addr[9:2]], v.chk_val);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    RESET = 1'b1; preload = 1'b1; inj = 2'd0; inj_addr = 32'h0;
    in_req_valid = 1'b0; in_req_store = 1'b0; in_req_size = 2'd0; in_req_signed = 1'b0;
    in_req_address = 32'h0; in_req_data = 32'h0; in_resp_ready = 1'b1;
    vecs[0]  = mk(1, 0, 0, 32'h101, 32'hAB, 32'h0, 0, 3, 1, 1, 0, 0, 1, 32'h100, 32'h4433AB11);
    vecs[1]  = mk(0, 1, 1, 32'h103, 0, 32'h00005544, 0, 3, 2, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 32'h107, 0, 32'hFFFFFF88, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h107, 0, 32'h00000088, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 2, 0, 32'h100, 0, 32'h4433AB11, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 2, 0, 32'h102, 32'hDEADBEEF, 32'h0, 0, 5, 2, 2, 0, 0, 1, 32'h104, 32'h8877DEAD);
    vecs[6]  = mk(0, 2, 0, 32'h102, 0, 32'hDEADBEEF, 0, 3, 2, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 32'h106, 0, 32'hFFFF8877, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 32'h107, 32'h5555, 32'h0, 1, 3, 2, 0, 1, 32'h108, 1, 32'h104, 32'h8877DEAD);
    vecs[9]  = mk(1, 2, 0, 32'h106, 32'h01020304, 32'h0, 1, 4, 2, 1, 2, 32'h104, 1, 32'h104, 32'h8877DEAD);
    vecs[10] = mk(0, 2, 0, 32'h100, 0, 32'h0, 1, 2, 1, 0, 1, 32'h100, 0, 0, 0);
    vecs[11] = mk(1, 2, 0, 32'h108, 32'h12345678, 32'h0, 0, 2, 0, 1, 0, 0, 1, 32'h108, 32'h12345678);
    vecs[12] = mk(0, 0, 1, 32'h10B, 0, 32'h00000012, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, 0, 32'h10B, 32'hCAFE, 32'h0, 0, 5, 2, 2, 0, 0, 1, 32'h10C, 32'h000000CA);
    vecs[14] = mk(0, 1, 0, 32'h10B, 0, 32'h0000CAFE, 0, 3, 2, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 3, 0, 32'h100, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 3, 0, 32'h101, 32'hFF, 32'h0, 1, 1, 0, 0, 0, 0, 1, 32'h100, 32'hBEEFAB11);
    vecs[17] = mk(0, 1, 0, 32'h101, 0, 32'h0000EFAB, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 0, 32'h100, 32'h1234, 32'h0, 0, 3, 1, 1, 0, 0, 1, 32'h100, 32'hBEEF1234);
    vecs[19] = mk(0, 1, 1, 32'hFFFFFFFF, 0, 32'hFFFFB2A1, 0, 3, 2, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 32'hFFFFFFFF, 32'h7F, 32'h0, 0, 3, 1, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h7F000000);
    vecs[21] = mk(0, 2, 0, 32'h0, 0, 32'h000000B2, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    @(negedge CLK);
    preload = 1'b0;
    check("reset req_ready", 32'(out_req_ready), 32'd1);
    check("reset resp_valid", 32'(out_resp_valid), 32'd0);
    check("reset resp_data", out_resp_data, 32'h0);
    check("reset resp_exc", 32'(out_resp_exception), 32'd0);
    check("reset we", 32'(out_mem_write_enable), 32'd0);
    check("reset raddr", out_mem_read_address, 32'h0);
    check("reset waddr", out_mem_write_address, 32'h0);
    check("reset wdata", out_mem_write_data, 32'h0);
    RESET = 1'b0;
    in_req_valid = 1'b1; in_req_store = 1'b1; in_req_size = 2'd2; in_req_signed = 1'b0;
    in_req_address = 32'h106; in_req_data = 32'h11112222;
    @(posedge CLK);
    @(negedge CLK);
    in_req_valid = 1'b0;
    t = 0;
    while (!out_mem_write_enable && t < 10) begin @(negedge CLK); t++; end
    check("midrst we seen", 32'(out_mem_write_enable), 32'd1);
    check("midrst waddr", out_mem_write_address, 32'h104);
    RESET = 1'b1;
    #1;
    check("midrst we drop", 32'(out_mem_write_enable), 32'd0);
    check("midrst req_ready", 32'(out_req_ready), 32'd1);
    check("midrst resp_valid", 32'(out_resp_valid), 32'd0);
    check("midrst waddr zero", out_mem_write_address, 32'h0);
    check("midrst wdata zero", out_mem_write_data, 32'h0);
    check("midrst raddr zero", out_mem_read_address, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    run_vec("midrst LW104", mk(0, 2, 0, 32'h104, 0, 32'h88776655, 0, 2, 1, 0, 0, 0, 1, 32'h108, 32'h0));
    for (int i = 0; i < 22; i++) run_vec($sformatf("v%0d", i), vecs[i]);
    in_resp_ready = 1'b0;
    in_req_valid = 1'b1; in_req_store = 1'b0; in_req_size = 2'd0; in_req_signed = 1'b0;
    in_req_address = 32'h107;
    @(posedge CLK);
    @(negedge CLK);
    in_req_valid = 1'b0;
    t = 0;
    while (!out_resp_valid && t < 10) begin @(negedge CLK); t++; end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold%0d valid", k), 32'(out_resp_valid), 32'd1);
      check($sformatf("hold%0d data", k), out_resp_data, 32'h00000088);
      check($sformatf("hold%0d exc", k), 32'(out_resp_exception), 32'd0);
      check($sformatf("hold%0d req_ready", k), 32'(out_req_ready), 32'd0);
      @(negedge CLK);
    end
    in_resp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("release valid", 32'(out_resp_valid), 32'd0);
    check("release req_ready", 32'(out_req_ready), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
